// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: owns the PC, drives a combinational-read instruction
// memory and presents fetched instructions to decode over a valid/ready handshake.
module fetch_sequencer #(
  parameter int         ADDR_W  = 5,
  parameter int         INST_W  = 16,
  parameter logic [2:0] HALT_OP = 3'b111
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [INST_W-1:0] imem_inst,
  output logic [INST_W-1:0] ir,
  output logic [ADDR_W-1:0] ir_pc,
  output logic              ir_valid,
  input  logic              ir_ready,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              busy,
  output logic              halted,
  output logic [15:0]       issued_cnt
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, HALTED} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [INST_W-1:0] ir_q, ir_d;
  logic [ADDR_W-1:0] ir_pc_q, ir_pc_d;
  logic              ir_valid_q, ir_valid_d;
  logic [15:0]       issued_cnt_q, issued_cnt_d;
  logic              busy_q, busy_d;
  logic              halted_q, halted_d;

  logic redirect_act;
  logic is_halt;
  logic accept;
  logic load;

  always_comb begin
    redirect_act = redirect && ((state_q == RUN) || (state_q == DRAIN));
    imem_addr    = redirect_act ? redirect_pc : pc_q;
    is_halt      = (imem_inst[INST_W-1 -: 3] == HALT_OP);
    accept       = ir_valid_q && ir_ready;
    // A redirect overrides backpressure and halt; otherwise RUN refills whenever ir frees up.
    load         = redirect_act || ((state_q == RUN) && (!ir_valid_q || ir_ready));

    state_d      = state_q;
    pc_d         = pc_q;
    ir_d         = ir_q;
    ir_pc_d      = ir_pc_q;
    ir_valid_d   = ir_valid_q;
    issued_cnt_d = issued_cnt_q;

    if (accept && !redirect_act) begin
      issued_cnt_d = issued_cnt_q + 16'd1;
    end

    case (state_q)
      IDLE, HALTED: begin
        if (start) begin
          state_d      = RUN;
          pc_d         = '0;
          issued_cnt_d = 16'd0;
        end
      end
      RUN, DRAIN: begin
        if (load) begin
          ir_d       = imem_inst;
          ir_pc_d    = imem_addr;
          ir_valid_d = 1'b1;
          pc_d       = imem_addr + ADDR_W'(1);
          state_d    = is_halt ? DRAIN : RUN;
        end else if (accept) begin
          ir_valid_d = 1'b0;
          if (state_q == DRAIN) begin
            state_d = HALTED;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d   = (state_d == RUN) || (state_d == DRAIN);
    halted_d = (state_d == HALTED);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      pc_q         <= '0;
      ir_q         <= '0;
      ir_pc_q      <= '0;
      ir_valid_q   <= 1'b0;
      issued_cnt_q <= 16'd0;
      busy_q       <= 1'b0;
      halted_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      ir_q         <= ir_d;
      ir_pc_q      <= ir_pc_d;
      ir_valid_q   <= ir_valid_d;
      issued_cnt_q <= issued_cnt_d;
      busy_q       <= busy_d;
      halted_q     <= halted_d;
    end
  end

  assign ir         = ir_q;
  assign ir_pc      = ir_pc_q;
  assign ir_valid   = ir_valid_q;
  assign issued_cnt = issued_cnt_q;
  assign busy       = busy_q;
  assign halted     = halted_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed testbench for fetch_sequencer: sequential fetch, backpressure, redirect,
// PC wrap, halt/restart and mid-run reset, each with hand-computed expectations.
module tb_fetch_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [4:0]  imem_addr;
  logic [15:0] imem_inst;
  logic [15:0] ir;
  logic [4:0]  ir_pc;
  logic        ir_valid;
  logic        ir_ready;
  logic        redirect;
  logic [4:0]  redirect_pc;
  logic        busy;
  logic        halted;
  logic [15:0] issued_cnt;

  logic [15:0] imem [32];
  int vectors    = 0;
  int miscompares = 0;

  assign imem_inst = imem[imem_addr];

  always #5 clk = ~clk;

  fetch_sequencer dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .imem_addr  (imem_addr),
    .imem_inst  (imem_inst),
    .ir         (ir),
    .ir_pc      (ir_pc),
    .ir_valid   (ir_valid),
    .ir_ready   (ir_ready),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .busy       (busy),
    .halted     (halted),
    .issued_cnt (issued_cnt)
  );

  // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; ir_ready = 1'b0; redirect = 1'b0; redirect_pc = '0;
    tick(); tick();
    rst = 1'b0;
    vectors++; if (ir_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_ir_valid got %0b want 0", ir_valid); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_busy got %0b want 0", busy); end
    vectors++; if (halted !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_halted got %0b want 0", halted); end
    vectors++; if (issued_cnt !== 16'd0) begin miscompares++; $display("[TB] FAIL reset_issued got %0d want 0", issued_cnt); end
    vectors++; if (ir !== 16'd0 || ir_pc !== 5'd0) begin miscompares++; $display("[TB] FAIL reset_ir got %h/%0d want 0/0", ir, ir_pc); end
    vectors++; if (imem_addr !== 5'd0) begin miscompares++; $display("[TB] FAIL reset_imem_addr got %0d want 0", imem_addr); end
  endtask

  task automatic test_sequential();
    start = 1'b1; ir_ready = 1'b1;
    tick();
    start = 1'b0;
    vectors++; if (busy !== 1'b1 || ir_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL seq_first_run busy=%0b valid=%0b want 1/0", busy, ir_valid); end
    vectors++; if (imem_addr !== 5'd0) begin miscompares++; $display("[TB] FAIL seq_first_addr got %0d want 0", imem_addr); end
    for (int i = 0; i <= 10; i++) begin
      tick();
      vectors++; if (ir_valid !== 1'b1 || ir_pc !== 5'(i) || ir !== 16'(i)) begin miscompares++; $display("[TB] FAIL seq_step%0d got v=%0b pc=%0d ir=%h want v=1 pc=%0d ir=%h", i, ir_valid, ir_pc, ir, i, i); end
      vectors++; if (issued_cnt !== 16'(i)) begin miscompares++; $display("[TB] FAIL seq_issued%0d got %0d want %0d", i, issued_cnt, i); end
    end
  endtask

  task automatic test_backpressure();
    rst = 1'b1; tick(); rst = 1'b0;
    start = 1'b1; ir_ready = 1'b1; tick(); start = 1'b0;
    for (int i = 0; i <= 4; i++) tick();
    vectors++; if (ir_pc !== 5'd4) begin miscompares++; $display("[TB] FAIL bp_pre got %0d want 4", ir_pc); end
    ir_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      vectors++; if (ir_valid !== 1'b1 || ir_pc !== 5'd4 || ir !== 16'd4) begin miscompares++; $display("[TB] FAIL bp_hold%0d got v=%0b pc=%0d ir=%h want 1/4/0004", i, ir_valid, ir_pc, ir); end
    end
    vectors++; if (issued_cnt !== 16'd4) begin miscompares++; $display("[TB] FAIL bp_issued_stall got %0d want 4", issued_cnt); end
    ir_ready = 1'b1;
    tick();
    vectors++; if (ir_pc !== 5'd5 || ir !== 16'd5) begin miscompares++; $display("[TB] FAIL bp_resume got pc=%0d ir=%h want 5/0005", ir_pc, ir); end
    vectors++; if (issued_cnt !== 16'd5) begin miscompares++; $display("[TB] FAIL bp_issued got %0d want 5", issued_cnt); end
  endtask

  task automatic test_redirect();
    tick();
    vectors++; if (ir_pc !== 5'd6 || issued_cnt !== 16'd6) begin miscompares++; $display("[TB] FAIL rd_pre got pc=%0d cnt=%0d want 6/6", ir_pc, issued_cnt); end
    ir_ready = 1'b0;
    tick();
    redirect = 1'b1; redirect_pc = 5'd12; ir_ready = 1'b1;
    #1;
    vectors++; if (imem_addr !== 5'd12) begin miscompares++; $display("[TB] FAIL rd_comb_addr got %0d want 12", imem_addr); end
    tick();
    redirect = 1'b0; ir_ready = 1'b0;
    vectors++; if (ir_valid !== 1'b1 || ir_pc !== 5'd12 || ir !== 16'd12) begin miscompares++; $display("[TB] FAIL rd_target got v=%0b pc=%0d ir=%h want 1/12/000c", ir_valid, ir_pc, ir); end
    vectors++; if (issued_cnt !== 16'd6) begin miscompares++; $display("[TB] FAIL rd_issued got %0d want 6", issued_cnt); end
    tick();
    vectors++; if (ir_pc !== 5'd12 || issued_cnt !== 16'd6) begin miscompares++; $display("[TB] FAIL rd_hold got pc=%0d cnt=%0d want 12/6", ir_pc, issued_cnt); end
  endtask

  task automatic test_wrap();
    logic [4:0] exp_pc [4];
    exp_pc[0] = 5'd30; exp_pc[1] = 5'd31; exp_pc[2] = 5'd0; exp_pc[3] = 5'd1;
    ir_ready = 1'b1; redirect = 1'b1; redirect_pc = 5'd30;
    tick();
    redirect = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) tick();
      vectors++; if (ir_pc !== exp_pc[i] || ir !== 16'(exp_pc[i])) begin miscompares++; $display("[TB] FAIL wrap%0d got pc=%0d ir=%h want %0d", i, ir_pc, ir, exp_pc[i]); end
      vectors++; if (issued_cnt !== 16'(6 + i)) begin miscompares++; $display("[TB] FAIL wrap_issued%0d got %0d want %0d", i, issued_cnt, 6 + i); end
    end
  endtask

  task automatic test_halt();
    imem[3] = 16'hF401;
    rst = 1'b1; tick(); rst = 1'b0;
    start = 1'b1; ir_ready = 1'b1; tick(); start = 1'b0;
    for (int i = 0; i <= 3; i++) begin
      tick();
      vectors++; if (ir_pc !== 5'(i) || ir_valid !== 1'b1) begin miscompares++; $display("[TB] FAIL halt_seq%0d got pc=%0d v=%0b want %0d/1", i, ir_pc, ir_valid, i); end
    end
    vectors++; if (ir !== 16'hF401 || busy !== 1'b1 || halted !== 1'b0) begin miscompares++; $display("[TB] FAIL halt_drain got ir=%h busy=%0b halted=%0b want f401/1/0", ir, busy, halted); end
    tick();
    vectors++; if (ir_valid !== 1'b0 || halted !== 1'b1 || busy !== 1'b0) begin miscompares++; $display("[TB] FAIL halt_done got v=%0b halted=%0b busy=%0b want 0/1/0", ir_valid, halted, busy); end
    vectors++; if (issued_cnt !== 16'd4 || imem_addr !== 5'd4) begin miscompares++; $display("[TB] FAIL halt_cnt_addr got cnt=%0d addr=%0d want 4/4", issued_cnt, imem_addr); end
    redirect = 1'b1; redirect_pc = 5'd7;
    #1;
    vectors++; if (imem_addr !== 5'd4) begin miscompares++; $display("[TB] FAIL halt_redirect_addr got %0d want 4", imem_addr); end
    tick();
    redirect = 1'b0;
    vectors++; if (ir_valid !== 1'b0 || halted !== 1'b1 || imem_addr !== 5'd4) begin miscompares++; $display("[TB] FAIL halt_stay got v=%0b halted=%0b addr=%0d want 0/1/4", ir_valid, halted, imem_addr); end
    imem[3] = 16'd3;
    start = 1'b1; tick(); start = 1'b0;
    vectors++; if (halted !== 1'b0 || busy !== 1'b1 || issued_cnt !== 16'd0) begin miscompares++; $display("[TB] FAIL restart got halted=%0b busy=%0b cnt=%0d want 0/1/0", halted, busy, issued_cnt); end
    tick();
    vectors++; if (ir_pc !== 5'd0 || ir !== 16'd0 || ir_valid !== 1'b1) begin miscompares++; $display("[TB] FAIL restart_fetch got pc=%0d ir=%h v=%0b want 0/0000/1", ir_pc, ir, ir_valid); end
  endtask

  task automatic test_reset_midrun();
    tick();
    vectors++; if (ir_valid !== 1'b1 || ir_pc !== 5'd1) begin miscompares++; $display("[TB] FAIL mid_pre got v=%0b pc=%0d want 1/1", ir_valid, ir_pc); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    vectors++; if (ir_valid !== 1'b0 || busy !== 1'b0 || halted !== 1'b0) begin miscompares++; $display("[TB] FAIL mid_rst got v=%0b busy=%0b halted=%0b want 0/0/0", ir_valid, busy, halted); end
    vectors++; if (issued_cnt !== 16'd0 || imem_addr !== 5'd0 || ir_pc !== 5'd0) begin miscompares++; $display("[TB] FAIL mid_rst_regs got cnt=%0d addr=%0d pc=%0d want 0/0/0", issued_cnt, imem_addr, ir_pc); end
    redirect = 1'b1; redirect_pc = 5'd9;
    #1;
    vectors++; if (imem_addr !== 5'd0) begin miscompares++; $display("[TB] FAIL idle_redirect_addr got %0d want 0", imem_addr); end
    tick(); tick();
    redirect = 1'b0;
    vectors++; if (ir_valid !== 1'b0 || busy !== 1'b0 || ir_pc !== 5'd0) begin miscompares++; $display("[TB] FAIL idle_redirect got v=%0b busy=%0b pc=%0d want 0/0/0", ir_valid, busy, ir_pc); end
  endtask

  initial begin
    for (int k = 0; k < 32; k++) imem[k] = 16'(k);
    rst = 1'b1; start = 1'b0; ir_ready = 1'b0; redirect = 1'b0; redirect_pc = '0;
    #1;
    test_reset();
    test_sequential();
    test_backpressure();
    test_redirect();
    test_wrap();
    test_halt();
    test_reset_midrun();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/fetch_sequencer.md
# fetch_sequencer

Sequencer that drives the 32-entry × 16-bit instruction memory and hands fetched instructions to decode through a valid/ready handshake. It owns the program counter and handles start, backpressure, redirects (branches/jumps) and halt detection. It sits between the instruction memory (combinational read) and the decode stage, and sustains one instruction per cycle when decode is ready.

## Interface
- ADDR_W, 5, instruction-memory address width; PC wraps modulo 2^ADDR_W
- INST_W, 16, instruction width
- HALT_OP, 3'b111, opcode (inst[15:13]) that terminates fetch
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  pulse; begins fetching at address 0 from IDLE or HALTED
- imem_addr  out  ADDR_W  address to instruction memory
- imem_inst  in  INST_W  instruction returned combinationally for imem_addr
- ir  out  INST_W  instruction presented to decode
- ir_pc  out  ADDR_W  address ir was fetched from
- ir_valid  out  1  ir/ir_pc are valid
- ir_ready  in  1  decode accepts ir this cycle
- redirect  in  1  flush and restart fetch at redirect_pc
- redirect_pc  in  ADDR_W  redirect target
- busy  out  1  state is RUN or DRAIN
- halted  out  1  state is HALTED
- issued_cnt  out  16  count of accepted handshakes, wraps at 2^16

## Operation
- States: IDLE, RUN, DRAIN, HALTED. Reset → IDLE, pc=0, ir=0, ir_pc=0, ir_valid=0, issued_cnt=0, halted=0, busy=0.
- IDLE: start → RUN, pc=0, issued_cnt=0. redirect ignored.
- RUN: load condition = !ir_valid || ir_ready. On load: ir←imem_inst, ir_pc←imem_addr, ir_valid←1, pc←imem_addr+1 (31+1 wraps to 0). Without load: ir, ir_pc, pc held stable.
- If ir_valid && ir_ready and no load occurs, ir_valid←0.
- If a loaded instruction has inst[15:13]==HALT_OP → DRAIN. No further fetches.
- DRAIN: ir holds the halt instruction; when ir_ready → ir_valid←0, state→HALTED.
- HALTED: halted=1; start → RUN with pc=0 and issued_cnt=0. redirect ignored.
- imem_addr = redirect_pc when redirect is asserted in RUN/DRAIN, otherwise pc.
- Redirect (RUN or DRAIN) has priority over backpressure and halt:
  - Any unaccepted ir is discarded. It is not counted, even if ir_ready is high that cycle.
  - imem[redirect_pc] loads into ir unconditionally, with ir_valid←1, ir_pc←redirect_pc and pc←redirect_pc+1.
  - State→RUN, or →DRAIN if the target is a halt instruction.
- issued_cnt increments on every ir_valid && ir_ready cycle without redirect.
- rst in any state, including mid-stall or in DRAIN, returns to IDLE reset values on the next edge.
- start in RUN/DRAIN is ignored.

## Timing
- start sampled at edge E0 → RUN from E0. imem_addr=0 during the following cycle. ir_valid=1 with ir=imem[0] after edge E1.
- Steady state with ir_ready=1: one new instruction per cycle, consecutive addresses, no bubbles.
- Backpressure: ir, ir_pc and ir_valid are stable while ir_valid && !ir_ready. Fetch resumes in the cycle ir_ready rises, so the next instruction appears one edge after acceptance.
- Redirect latency: asserted in cycle n → ir=imem[redirect_pc] and ir_valid=1 after edge n. Zero bubbles.
- Halt: halt instruction visible in ir at cycle h. halted=1 one edge after its acceptance. busy=0 at the same edge.
- Combinational paths: redirect/redirect_pc → imem_addr. Only registered state drives ir_valid and ir.

## Test plan
- Reset, then start with imem[k]=k (no HALT_OP), ir_ready=1 → ir_pc sequence 0,1,2,… one per cycle. imem_addr=0 in the first RUN cycle. issued_cnt=10 after 10 accepts.
- Backpressure: drop ir_ready for 3 cycles while ir_pc=4 → ir and ir_pc held at 4 for those cycles. Next cycle after ir_ready rises shows ir_pc=5. No address is skipped or duplicated.
- Redirect to 12 while ir_pc=6 is stalled (ir_ready=0) → next cycle ir_pc=12, ir=imem[12]. Address 6 is never accepted. issued_cnt is unchanged by the flush.
- Wrap: redirect to 30 with ir_ready=1 → ir_pc sequence 30,31,0,1.
- Halt: imem[3]=16'b111_1_0100_00000001 and ir_ready=1 → ir_pc 0..3, then ir_valid=0, halted=1, busy=0, imem_addr stable. A later start → ir_pc=0 again and issued_cnt restarts from 0.
- rst asserted mid-run with ir_valid=1 → next cycle ir_valid=0, state IDLE, pc=0, issued_cnt=0. Subsequent redirect pulses produce no fetch.
